traffic_checker: RTL and testbench

TRAFFIC_CHECKER -- requirements
Module: cache_traffic_checker

---
 rtl/traffic_checker.sv | 202 ++++++++++++++++++++
 tb/tb_traffic_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_checker.sv
// Cache traffic generator/checker: random write bursts and replayed read bursts, read data checked against a shadow RAM.
// One operation in flight; stalls in WAIT while busy=1. Optional busy watchdog under `TGEN_TIMEOUT_EN`.
module traffic_checker #(
  parameter int          TAG_BITS       = 4,
  parameter int          SET_BITS       = 5,
  parameter int          WORD_BITS      = 4,
  parameter int          HIST_DEPTH     = 16,
  parameter int          NUM_OPS        = 1024,
  parameter logic [31:0] SEED           = 32'h00000064,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 rreq,
  output logic                 wreq,
  output logic [31:0]          addr,
  output logic [WORD_BITS:0]   burst_size,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  input  logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           err_code,
  output logic [31:0]          err_addr,
  output logic [31:0]          err_expected,
  output logic [31:0]          err_actual,
  output logic [15:0]          op_count
);
  localparam int HB       = $clog2(HIST_DEPTH);
  localparam int IDX_BITS = TAG_BITS + SET_BITS + WORD_BITS;
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS    = 32'h80200003;
  localparam logic [WORD_BITS:0] LINE_WORDS = (WORD_BITS+1)'(1 << WORD_BITS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PICK = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_XFER = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_FAIL = 3'd6;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [SET_BITS-1:0]  set;
    logic [WORD_BITS-1:0] word;
    logic [WORD_BITS:0]   burst;
  } hist_t;

  logic [2:0]           state;
  logic [31:0]          lfsr;
  hist_t                cur;
  logic                 is_wr;
  logic [WORD_BITS:0]   beat;
  hist_t                hist_q [HIST_DEPTH];
  logic [HB-1:0]        hist_ptr;
  logic [HB:0]          hist_count;
  logic [31:0]          shadow [0:(1<<IDX_BITS)-1];

  logic [31:0]          lfsr_nxt;
  logic                 beat_act, last_beat, mism, push;
  logic [WORD_BITS-1:0] word_j;
  logic [IDX_BITS-1:0]  sh_idx;
  logic [HB:0]          cnt_m1;
  logic [HB-1:0]        rd_idx;
  hist_t                wr_pick;

`ifdef TGEN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Beat 0 lands in the WAIT cycle where busy is first seen low; later beats run in XFER.
  always_comb begin
    lfsr_nxt   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);
    beat_act   = (state == S_WAIT && !busy) || (state == S_XFER);
    last_beat  = (beat == cur.burst - 1'b1);
    word_j     = cur.word + beat[WORD_BITS-1:0];
    sh_idx     = {cur.tag, cur.set, word_j};
    mism       = beat_act && !is_wr && (rdata != shadow[sh_idx]);
    push       = beat_act && is_wr && last_beat;
    cnt_m1     = hist_count - 1'b1;
    rd_idx     = ({1'b0, lfsr[1 +: HB]} >= hist_count) ? cnt_m1[HB-1:0] : lfsr[1 +: HB];
    wr_pick.word  = lfsr[1 +: WORD_BITS];
    wr_pick.set   = lfsr[1 + WORD_BITS +: SET_BITS];
    wr_pick.tag   = lfsr[1 + WORD_BITS + SET_BITS +: TAG_BITS];
    wr_pick.burst = LINE_WORDS - {1'b0, wr_pick.word};
  end

  assign rreq       = (state == S_REQ) && !is_wr;
  assign wreq       = (state == S_REQ) && is_wr;
  assign addr       = 32'({cur.tag, cur.set, cur.word, 2'b00});
  assign burst_size = cur.burst;
  assign wdata      = (is_wr && (state == S_WAIT || state == S_XFER)) ? {22'd0, lfsr[9:0]} : 32'd0;

  always_ff @(posedge clk) begin
    if (beat_act && is_wr) shadow[sh_idx] <= wdata;
    if (push)              hist_q[hist_ptr] <= cur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      lfsr         <= SEED_NZ;
      cur          <= '0;
      is_wr        <= 1'b0;
      beat         <= '0;
      hist_ptr     <= '0;
      hist_count   <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_code     <= 2'b00;
      err_addr     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      op_count     <= '0;
`ifdef TGEN_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            op_count     <= '0;
            err_code     <= 2'b00;
            err_addr     <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            hist_ptr     <= '0;
            hist_count   <= '0;
            state        <= S_PICK;
          end
        end
        S_PICK: begin
          lfsr <= lfsr_nxt;
          if (hist_count != '0 && !lfsr[0]) begin
            is_wr <= 1'b0;
            cur   <= hist_q[rd_idx];
          end else begin
            is_wr <= 1'b1;
            cur   <= wr_pick;
          end
          state <= S_REQ;
        end
        S_REQ: begin
          beat  <= '0;
          state <= S_WAIT;
`ifdef TGEN_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT, S_XFER: begin
          if (beat_act) begin
            if (is_wr) lfsr <= lfsr_nxt;
            if (mism) begin
              err_code     <= 2'b01;
              err_addr     <= 32'({cur.tag, cur.set, word_j, 2'b00});
              err_expected <= shadow[sh_idx];
              err_actual   <= rdata;
              done         <= 1'b1;
              pass         <= 1'b0;
              state        <= S_FAIL;
            end else if (last_beat) begin
              op_count <= op_count + 16'd1;
              if (push) begin
                hist_ptr <= hist_ptr + 1'b1;
                if (hist_count != (HB+1)'(HIST_DEPTH)) hist_count <= hist_count + 1'b1;
              end
              if (op_count + 16'd1 == 16'(NUM_OPS)) begin
                done  <= 1'b1;
                pass  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_PICK;
              end
            end else begin
              beat  <= beat + 1'b1;
              state <= S_XFER;
            end
          end
`ifdef TGEN_TIMEOUT_EN
          else if (state == S_WAIT) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              err_code <= 2'b10;
              err_addr <= addr;
              done     <= 1'b1;
              pass     <= 1'b0;
              state    <= S_FAIL;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_checker.sv
// Bench for traffic_checker: ideal cache model with a word-addressed memory, table of run scenarios,
// plus hand sequences for busy watchdog, reset inside a write burst, and start during WAIT.
module tb_traffic_checker;
  localparam int NOPS = 64;
  localparam int HD   = 4;

  typedef struct {
    int         lat;
    bit         corrupt;
    bit         start_wait;
    bit         exp_done;
    bit         exp_pass;
    logic [1:0] exp_code;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b1;
  logic [31:0] rdata = '0;
  logic        rreq, wreq, done, pass;
  logic [31:0] addr, wdata, err_addr, err_expected, err_actual;
  logic [4:0]  burst_size;
  logic [1:0]  err_code;
  logic [15:0] op_count;

  traffic_checker #(.HIST_DEPTH(HD), .NUM_OPS(NOPS)) dut (
    .clk(clk), .reset(reset), .start(start), .rreq(rreq), .wreq(wreq), .addr(addr),
    .burst_size(burst_size), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .err_addr(err_addr), .err_expected(err_expected), .err_actual(err_actual),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int mon_bad = 0;
  int hold_bad = 0;
  logic [31:0] mem [0:8191];
  logic [17:0] mh [HD];
  int mh_cnt, mh_ptr, wr_cnt, ops, burst_bad, rd_bad;
  bit first_wr, stopped;
  logic [31:0] e_addr, e_exp;
  vec_t vecs [4];

  always @(negedge clk) if (rreq && wreq) mon_bad++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] key_of(input logic [31:0] a, input logic [4:0] n);
    return {a[14:2], n};
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy = 1'b1;
      if (rreq || wreq) begin got = 1'b1; break; end
      if (done) break;
    end
  endtask

  task automatic serve_beats(input logic [31:0] a, input int n, input bit wr, input bit corrupt);
    logic [12:0] idx;
    stopped = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      busy = 1'b0;
      start = 1'b0;
      if (addr !== a || int'(burst_size) != n) hold_bad++;
      idx = a[14:2] + 13'(j);
      if (wr) begin
        #1 mem[idx] = wdata;
      end else if (corrupt && j == 3) begin
        rdata   = mem[idx] + 32'd1;
        e_addr  = a + 32'd12;
        e_exp   = mem[idx];
        stopped = 1'b1;
        return;
      end else begin
        rdata = mem[idx];
      end
    end
  endtask

  task automatic do_run(input vec_t v);
    bit got, wr, found;
    logic [31:0] a;
    logic [17:0] h0;
    int n, guard;
    pulse_start();
    ops = 0; wr_cnt = 0; mh_cnt = 0; mh_ptr = 0; burst_bad = 0; rd_bad = 0;
    first_wr = 1'b0; stopped = 1'b0; got = 1'b1; guard = 0;
    while (!done && got && guard < NOPS + 4) begin
      guard++;
      wait_req(got);
      if (got) begin
        a = addr; n = int'(burst_size); wr = wreq;
        if (guard == 1) first_wr = wr;
        if (wr && n != 16 - int'(a[5:2])) burst_bad++;
        if (!wr) begin
          found = 1'b0;
          for (int k = 0; k < mh_cnt; k++) if (mh[k] == key_of(a, 5'(n))) found = 1'b1;
          if (!found) rd_bad++;
        end
        for (int i = 0; i < v.lat; i++) begin
          @(negedge clk);
          busy  = 1'b1;
          start = (v.start_wait && guard == 2 && i == 0);
        end
        serve_beats(a, n, wr, v.corrupt && !wr && n >= 4);
        @(posedge clk); #1;
        if (!stopped) begin
          ops++;
          if (wr) begin
            mh[mh_ptr] = key_of(a, 5'(n));
            mh_ptr = (mh_ptr + 1) % HD;
            if (mh_cnt < HD) mh_cnt++;
            wr_cnt++;
            if (wr_cnt == HD + 1) begin
              h0 = dut.hist_q[0];
              check("hist_count_saturates", 32'(dut.hist_count), HD);
              check("hist_entry0_overwritten", 32'(h0), 32'(key_of(a, 5'(n))));
            end
          end
        end
      end
    end
    check("run_done", done, v.exp_done);
    check("run_pass", pass, v.exp_pass);
    check("run_err_code", err_code, v.exp_code);
    check("run_op_count", op_count, ops);
    check("first_op_is_write", first_wr, 1);
    check("write_burst_rule", burst_bad, 0);
    check("read_replays_history", rd_bad, 0);
    if (v.corrupt) begin
      check("mism_err_addr", err_addr, e_addr);
      check("mism_err_expected", err_expected, e_exp);
      check("mism_err_actual", err_actual, e_exp + 32'd1);
    end
  endtask

  initial begin
    bit got, wr, found_wr;
    logic [31:0] a;
    int n;

    for (int i = 0; i < 8192; i++) mem[i] = '0;
    vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[1] = '{2, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[2] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
    vecs[3] = '{3, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};

    repeat (3) @(negedge clk);
    check("rst_rreq", rreq, 0);
    check("rst_wreq", wreq, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_code", err_code, 0);
    check("rst_addr", addr, 0);
    check("rst_burst", burst_size, 0);
    check("rst_wdata", wdata, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_op_count", op_count, 0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) do_run(vecs[i]);

    // Busy held high for 300 cycles on the first operation of a run.
    pulse_start();
    wait_req(got);
    check("to_req_seen", got, 1);
    a = addr; n = int'(burst_size); wr = wreq;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
`ifdef TGEN_TIMEOUT_EN
      if (i == 256) check("to_not_yet", err_code, 2'b00);
      if (i == 257) begin
        check("to_err_code", err_code, 2'b10);
        check("to_err_addr", err_addr, a);
        check("to_done", done, 1);
      end
`endif
      busy = 1'b1;
    end
`ifdef TGEN_TIMEOUT_EN
    pulse_start();
`else
    check("no_timeout_code", err_code, 2'b00);
    check("no_timeout_done", done, 0);
    serve_beats(a, n, wr, 1'b0);
    @(posedge clk); #1;
    check("long_wait_op_completes", op_count, 1);
`endif

    // Reset asserted in the middle of a write burst.
    found_wr = 1'b0;
    for (int t = 0; t < 40 && !found_wr; t++) begin
      wait_req(got);
      if (!got) break;
      a = addr; n = int'(burst_size); wr = wreq;
      if (wr && n >= 2) begin
        found_wr = 1'b1;
        @(negedge clk); busy = 1'b0;
        #1 mem[a[14:2]] = wdata;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("rst_mid_rreq", rreq, 0);
        check("rst_mid_wreq", wreq, 0);
        check("rst_mid_op_count", op_count, 0);
        check("rst_mid_done", done, 0);
        busy = 1'b1;
        reset = 1'b1;
      end else begin
        serve_beats(a, n, wr, 1'b0);
        @(posedge clk); #1;
      end
    end
    check("rst_mid_write_found", found_wr, 1);

    do_run(vecs[0]);

    check("never_rreq_and_wreq", mon_bad, 0);
    check("addr_burst_hold", hold_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
